// File: rtl/inst_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory and holds the core in reset until it lands.
// mem_we follows the 4th byte of each word by one cycle; byte_ready depends only on state, so gap-free streaming is sustained.
module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_t;

    state_t            state_q;
    logic [7:0]        len_lo_q;
    logic [16:0]       len_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       word_q;
    logic [7:0]        csum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic        accept;
    logic [7:0]  csum_d;
    logic [16:0] n_len;
    logic        len_bad;
    logic        last_word;

    assign byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CSUM);
    assign accept     = byte_valid && byte_ready;
    assign csum_d     = csum_q ^ byte_data;
    assign n_len      = {1'b0, byte_data, len_lo_q};
    assign len_bad    = (n_len == 17'd0) || (n_len > (17'd1 << ADDR_W));
    assign last_word  = (17'(word_idx_q) + 17'd1) == len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (start && (state_q == IDLE || state_q == ERR)) begin
                // byte_ready is low in both states, so a coincident byte is left for LEN0
                state_q    <= LEN0;
                cpu_hold_q <= 1'b1;
                busy_q     <= 1'b1;
                err_q      <= 1'b0;
                word_idx_q <= '0;
                byte_cnt_q <= '0;
                csum_q     <= '0;
            end else if (accept) begin
                csum_q <= csum_d;
                case (state_q)
                    LEN0: begin
                        len_lo_q <= byte_data;
                        state_q  <= LEN1;
                    end
                    LEN1: begin
                        len_q <= n_len;
                        if (len_bad) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        word_q     <= {byte_data, word_q[23:8]};
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_idx_q;
                            mem_wdata_q <= {byte_data, word_q};
                            word_idx_q  <= word_idx_q + 1'b1;
                            if (last_word) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        busy_q <= 1'b0;
                        if (byte_data == csum_q) begin
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
